// File: rtl/lfsr_rng_arbiter.sv
// Round-robin grant of sampled words from one shared 16-bit LFSR engine.
// The engine is stepped through a warm-up after reset and a fixed stride after every grant.
module lfsr_rng_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WARMUP_CYCLES  = 16,
    parameter int STEPS_PER_WORD = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [15:0]        rnd_data,
    output logic               lfsr_en,
    input  logic [15:0]        lfsr_q,
    output logic               busy,
    output logic [15:0]        served_cnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_READY  = 2'd1,
        S_STEP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_cnt;
    logic [PW-1:0]      r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_rnd_valid;
    logic [15:0]        r_rnd_data;
    logic [15:0]        r_served_cnt;

    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_ptr_nxt;
    logic [NUM_REQ-1:0] w_onehot;

    // Rotating priority search starting at r_ptr; index wraps without a modulo operator.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(r_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
    end

    assign w_ptr_nxt = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + PW'(1);
    assign w_onehot  = NUM_REQ'(1) << w_win;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_WARMUP;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_rnd_valid  <= 1'b0;
            r_rnd_data   <= 16'h0000;
            r_served_cnt <= 16'h0000;
        end else begin
            // Grant pulse lives for exactly the first STEP cycle.
            r_gnt       <= '0;
            r_rnd_valid <= 1'b0;
            case (r_state)
                S_WARMUP: begin
                    if (r_cnt == 32'(WARMUP_CYCLES - 1)) begin
                        r_state <= S_READY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_READY: begin
                    if (w_found) begin
                        r_gnt        <= w_onehot;
                        r_rnd_valid  <= 1'b1;
                        r_rnd_data   <= lfsr_q;
                        r_ptr        <= w_ptr_nxt;
                        r_served_cnt <= r_served_cnt + 16'd1;
                        r_state      <= S_STEP;
                        r_cnt        <= '0;
                    end
                end
                S_STEP: begin
                    if (r_cnt == 32'(STEPS_PER_WORD - 1)) begin
                        r_state <= S_READY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_WARMUP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign lfsr_en    = (r_state == S_WARMUP) || (r_state == S_STEP);
    assign busy       = lfsr_en;
    assign gnt        = r_gnt;
    assign rnd_valid  = r_rnd_valid;
    assign rnd_data   = r_rnd_data;
    assign served_cnt = r_served_cnt;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench: default arbiter plus a NUM_REQ=2 / 1-step corner instance, each fed by an LFSR stub.
module tb_lfsr_rng_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        rnd_valid;
    logic [15:0] rnd_data;
    logic        lfsr_en;
    logic [15:0] lfsr_q;
    logic        busy;
    logic [15:0] served_cnt;

    logic [1:0]  req2;
    logic [1:0]  gnt2;
    logic        rnd_valid2;
    logic [15:0] rnd_data2;
    logic        lfsr_en2;
    logic [15:0] lfsr_q2;
    logic        busy2;
    logic [15:0] served_cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lfsr_rng_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .rnd_valid(rnd_valid),
        .rnd_data(rnd_data), .lfsr_en(lfsr_en), .lfsr_q(lfsr_q), .busy(busy),
        .served_cnt(served_cnt)
    );

    lfsr_rng_arbiter #(.NUM_REQ(2), .WARMUP_CYCLES(1), .STEPS_PER_WORD(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .req(req2), .gnt(gnt2), .rnd_valid(rnd_valid2),
        .rnd_data(rnd_data2), .lfsr_en(lfsr_en2), .lfsr_q(lfsr_q2), .busy(busy2),
        .served_cnt(served_cnt2)
    );

    // Engine stubs: 0xA000 plus the number of enabled edges since reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q  <= 16'hA000;
            lfsr_q2 <= 16'hA000;
        end else begin
            if (lfsr_en)  lfsr_q  <= lfsr_q + 16'd1;
            if (lfsr_en2) lfsr_q2 <= lfsr_q2 + 16'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Waits (bounded) for the next grant on the main DUT; cycles=-1 on timeout.
    int          w_cycles;
    int          w_en_hi;
    int          w_multi;
    logic [3:0]  w_gnt;
    logic [15:0] w_data;
    logic        w_vld;
    logic [15:0] w_served;

    task automatic wait_gnt();
        w_cycles = -1;
        w_en_hi  = 0;
        w_multi  = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (lfsr_en) w_en_hi++;
            if ($countones(gnt) > 1) w_multi++;
            if (gnt != 4'b0) begin
                w_cycles = c;
                w_gnt    = gnt;
                w_data   = rnd_data;
                w_vld    = rnd_valid;
                w_served = served_cnt;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic [3:0] req_at_release);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        req     = req_at_release;
        reset_n = 1'b1;
    endtask

    initial begin
        int en_cnt, bad_gnt, bad_busy;
        logic [3:0]  rr_exp [5];
        logic [15:0] rr_dat [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_dat = '{16'hA010, 16'hA020, 16'hA030, 16'hA040, 16'hA050};

        reset_n = 1'b0;
        req     = '0;
        req2    = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_vld", 32'(rnd_valid), 0);
        chk("rst_data", 32'(rnd_data), 0);
        chk("rst_served", 32'(served_cnt), 0);

        // Warm-up with no requests.
        reset_n  = 1'b1;
        en_cnt   = 0;
        bad_gnt  = 0;
        bad_busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (lfsr_en) en_cnt++;
            if (gnt != 0 || rnd_valid || served_cnt != 0) bad_gnt++;
            if (busy !== lfsr_en) bad_busy++;
            @(negedge clk);
        end
        chk("warm_en_cycles", 32'(en_cnt), 16);
        chk("warm_no_gnt", 32'(bad_gnt), 0);
        chk("warm_busy_eq_en", 32'(bad_busy), 0);
        chk("warm_lfsr_q", 32'(lfsr_q), 32'hA010);

        // Single requester.
        req = 4'b0001;
        wait_gnt();
        chk("single1_lat", 32'(w_cycles), 1);
        chk("single1_gnt", 32'(w_gnt), 32'b0001);
        chk("single1_vld", 32'(w_vld), 1);
        chk("single1_data", 32'(w_data), 32'hA010);
        chk("single1_served", 32'(w_served), 1);
        wait_gnt();
        chk("single2_lat", 32'(w_cycles), 17);
        chk("single2_en_cycles", 32'(w_en_hi), 16);
        chk("single2_gnt", 32'(w_gnt), 32'b0001);
        chk("single2_data", 32'(w_data), 32'hA020);
        chk("single2_served", 32'(w_served), 2);
        req = 4'b0000;

        // Round-robin from reset, all requesting; first grant WARMUP+1 edges after release.
        do_reset(4'b1111);
        for (int g = 0; g < 5; g++) begin
            wait_gnt();
            chk($sformatf("rr%0d_lat", g), 32'(w_cycles), 17);
            chk($sformatf("rr%0d_gnt", g), 32'(w_gnt), 32'(rr_exp[g]));
            chk($sformatf("rr%0d_data", g), 32'(w_data), 32'(rr_dat[g]));
            chk($sformatf("rr%0d_onehot", g), 32'(w_multi), 0);
        end
        req = 4'b0000;

        // Request raised during warm-up is held until READY.
        do_reset(4'b0000);
        repeat (2) @(negedge clk);
        req = 4'b0100;
        wait_gnt();
        chk("early_lat", 32'(w_cycles), 15);
        chk("early_gnt", 32'(w_gnt), 32'b0100);
        chk("early_data", 32'(w_data), 32'hA010);
        req = 4'b0000;

        // Reset in the middle of STEP.
        do_reset(4'b1111);
        wait_gnt();
        chk("midstep_first_gnt", 32'(w_gnt), 32'b0001);
        repeat (4) @(negedge clk);
        chk("midstep_gnt_clear", 32'(gnt), 0);
        chk("midstep_served", 32'(served_cnt), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_vld", 32'(rnd_valid), 0);
        chk("midrst_data", 32'(rnd_data), 0);
        chk("midrst_served", 32'(served_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_gnt();
        chk("midrst_regrant_lat", 32'(w_cycles), 17);
        chk("midrst_regrant_en", 32'(w_en_hi), 16);
        chk("midrst_regrant_gnt", 32'(w_gnt), 32'b0001);
        chk("midrst_regrant_data", 32'(w_data), 32'hA010);
        req = 4'b0000;

        // Corner instance: idle in READY since its 1-cycle warm-up.
        @(negedge clk);
        force dut2.r_served_cnt = 16'hFFFF;
        #1 release dut2.r_served_cnt;
        chk("c_preload", 32'(served_cnt2), 32'hFFFF);
        req2 = 2'b11;
        @(negedge clk);
        chk("c_g0", 32'(gnt2), 32'b01);
        chk("c_g0_data", 32'(rnd_data2), 32'hA001);
        chk("c_wrap", 32'(served_cnt2), 0);
        @(negedge clk);
        chk("c_gap0", 32'(gnt2), 0);
        @(negedge clk);
        chk("c_g1", 32'(gnt2), 32'b10);
        chk("c_g1_data", 32'(rnd_data2), 32'hA002);
        chk("c_g1_served", 32'(served_cnt2), 1);
        @(negedge clk);
        chk("c_gap1", 32'(gnt2), 0);
        @(negedge clk);
        chk("c_g2", 32'(gnt2), 32'b01);
        chk("c_g2_data", 32'(rnd_data2), 32'hA003);
        req2 = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
